// File: rtl/ysyx_22040125_if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ysyx_22040125_if_fetch_pkg;

  // Default PC of the first fetch after reset.
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  // Instruction word presented when no fetched entry is available.
  localparam logic [31:0] NOP_BUBBLE = 32'hffff_ffff;

  // Fetch FSM: issue a request, wait for its response, or drop a stale response.
  typedef enum logic [1:0] {
    StReq     = 2'd0,
    StWait    = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

  // One buffered fetch result.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Word-align a fetch address.
  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22040125_fetch_fifo.sv
// Small synchronous FIFO holding fetched entries, with single-cycle flush.
module ysyx_22040125_fetch_fifo
  import ysyx_22040125_if_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  fetch_entry_t                   push_data,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   head,
  output logic [$clog2(Depth+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  fetch_entry_t  mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en;
  logic          pop_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(Depth));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign pop_en  = pop & ~empty & ~flush;
  assign push_en = push & ~flush & (~full | pop_en);

  // Pointer and occupancy next state; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only observed while count is non-zero, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ysyx_22040125_if_fetch.sv
// Instruction-fetch front end: PC ownership, single-outstanding imem requests,
// fetch buffering and the IF/ID producer interface (instr/pc/err + bubble).
module ysyx_22040125_if_fetch
  import ysyx_22040125_if_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        if_err,
  output logic        if_bubble
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic          started_q;
  logic          req_fire;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;

  // Requests only go out with a free slot reserved, so a response never overflows.
  assign imem_req_valid = started_q & (state_q == StReq) & ~fifo_full;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A redirect cancels the pop: the head belongs to the wrong path.
  assign pop = ~stall & ~fifo_empty & ~redirect_valid;

  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = imem_resp_data;
  assign push_entry.err   = imem_resp_err;

  // Fetch FSM and PC next state; redirect overrides the PC in every state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    unique case (state_q)
      StReq: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          state_d  = redirect_valid ? StDiscard : StWait;
        end
      end
      StWait: begin
        if (imem_resp_valid) begin
          push    = ~redirect_valid;
          state_d = StReq;
        end else if (redirect_valid) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (imem_resp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end
  end

  // FSM, PC and request-PC registers; started_q holds off the first request
  // until one clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StReq;
      pc_q      <= word_align(RESET_PC);
      req_pc_q  <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      started_q <= 1'b1;
    end
  end

  ysyx_22040125_fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // IF/ID outputs straight from the buffer head, masked when nothing is buffered.
  always_comb begin
    if_instr  = NOP_BUBBLE;
    if_pc     = '0;
    if_err    = 1'b0;
    if_bubble = redirect_valid | fifo_empty;
    if (!fifo_empty) begin
      if_instr = head.instr;
      if_pc    = head.pc;
      if_err   = head.err;
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_if_fetch.sv
// Directed bench for the fetch front end; memory is driven by hand, cycle by cycle.
module tb_ysyx_22040125_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_err;
  logic        if_bubble;

  int checks;
  int failures;

  ysyx_22040125_if_fetch #(
    .RESET_PC   (64'h0000_0000_8000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_err          (if_err),
    .if_bubble       (if_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From REQ with a handshake pending: accept, then return a response one cycle later.
  task automatic serve(input logic [31:0] d, input logic e);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = d;
    imem_resp_err   = e;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_resp_data  = 32'h0;
    #1;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_bubble", if_bubble, 1);
    chk("rst_instr", if_instr, 32'hffff_ffff);
    chk("rst_pc", if_pc, 0);
    chk("rst_err", if_err, 0);

    // Release: no request until one clock later
    rst = 1'b1;
    #1;
    chk("rel_no_req", imem_req_valid, 0);
    tick();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 64'h8000_0000);

    // Sequential fetch
    serve(32'h1111_0000, 1'b0);
    chk("f0_pc", if_pc, 64'h8000_0000);
    chk("f0_instr", if_instr, 32'h1111_0000);
    chk("f0_bubble", if_bubble, 0);
    chk("f1_addr", imem_req_addr, 64'h8000_0004);
    serve(32'h1111_0001, 1'b0);
    chk("f1_pc", if_pc, 64'h8000_0004);
    chk("f1_instr", if_instr, 32'h1111_0001);

    // Access fault on 8000_0008 only
    serve(32'h1111_0002, 1'b1);
    chk("e_pc", if_pc, 64'h8000_0008);
    chk("e_err", if_err, 1);
    serve(32'h1111_0003, 1'b0);
    chk("e_next_pc", if_pc, 64'h8000_000c);
    chk("e_next_err", if_err, 0);

    // Stall: fill both slots, requests stop while full
    serve(32'h1111_0004, 1'b0);
    chk("s_head0", if_pc, 64'h8000_0010);
    stall = 1'b1;
    serve(32'h1111_0005, 1'b0);
    chk("s_full_noreq", imem_req_valid, 0);
    chk("s_head_held", if_pc, 64'h8000_0010);
    chk("s_bubble", if_bubble, 0);
    tick();
    tick();
    tick();
    chk("s_still_noreq", imem_req_valid, 0);
    chk("s_still_head", if_instr, 32'h1111_0004);
    stall = 1'b0;
    #1;
    chk("s_rel_noreq", imem_req_valid, 0);
    tick();
    chk("s_second_pc", if_pc, 64'h8000_0014);
    chk("s_second_instr", if_instr, 32'h1111_0005);
    chk("s_req_resume", imem_req_valid, 1);
    chk("s_req_addr", imem_req_addr, 64'h8000_0018);
    serve(32'h1111_0006, 1'b0);
    chk("s_next_pc", if_pc, 64'h8000_0018);

    // Redirect while WAIT: response dropped, refetch from aligned target
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    #1;
    chk("rw_bubble", if_bubble, 1);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rw_discard_noreq", imem_req_valid, 0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdead_0001;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("rw_dropped", if_instr, 32'hffff_ffff);
    chk("rw_req_valid", imem_req_valid, 1);
    chk("rw_req_addr", imem_req_addr, 64'h8000_0100);

    // Redirect coincident with the request handshake
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    #1;
    chk("rh_req_valid", imem_req_valid, 1);
    tick();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdead_0002;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("rh_addr", imem_req_addr, 64'h8000_0200);
    chk("rh_pc", if_pc, 0);
    chk("rh_bubble", if_bubble, 1);

    // Redirect coincident with the response in WAIT
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdead_0003;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h8000_0300;
    #1;
    chk("rr_bubble", if_bubble, 1);
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    #1;
    chk("rr_pc", if_pc, 0);
    chk("rr_req_valid", imem_req_valid, 1);
    chk("rr_addr", imem_req_addr, 64'h8000_0300);

    // Redirect under stall flushes a non-empty buffer
    serve(32'h1111_0008, 1'b0);
    chk("rs_head", if_pc, 64'h8000_0300);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    #1;
    chk("rs_bubble", if_bubble, 1);
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rs_flushed", if_pc, 0);
    chk("rs_flush_bubble", if_bubble, 1);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdead_0004;
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("rs_addr", imem_req_addr, 64'h8000_0400);

    // Reset while WAIT with a late response
    tick();
    rst = 1'b0;
    #1;
    chk("rm_noreq", imem_req_valid, 0);
    chk("rm_bubble", if_bubble, 1);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdead_0005;
    tick();
    rst = 1'b1;
    #1;
    chk("rm_rel_noreq", imem_req_valid, 0);
    tick();
    imem_resp_valid = 1'b0;
    #1;
    chk("rm_empty", if_instr, 32'hffff_ffff);
    chk("rm_req_valid", imem_req_valid, 1);
    chk("rm_addr", imem_req_addr, 64'h8000_0000);

    // Redirect in REQ without handshake, then PC wrap at 2^64
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hffff_ffff_ffff_ffff;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("wr_addr", imem_req_addr, 64'hffff_ffff_ffff_fffc);
    serve(32'h1111_0009, 1'b0);
    chk("wr_head_pc", if_pc, 64'hffff_ffff_ffff_fffc);
    chk("wr_next_addr", imem_req_addr, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
